// File: rtl/frontend_sync_monitor.sv
// Qualifies the ISL51002 regenerated sync stream and publishes locked htotal/vtotal/interlace; sticky IRQ under SYNC_MON_IRQ_EN.
// Latency: frame edge sampled at k -> state/outputs at k+2; no backpressure, every frame is evaluated.
module frontend_sync_monitor #(
    parameter int unsigned LOCK_FRAMES = 4,
    parameter int unsigned MISS_LIMIT  = 2,
    parameter int unsigned HTOL        = 2,
    parameter int unsigned VTOL        = 1,
    parameter int unsigned HS_TIMEOUT  = 8191
) (
    input  logic        PCLK_i,
    input  logic        reset_i,
    input  logic        HSYNC_i,
    input  logic        frame_change_i,
    input  logic [10:0] vtotal_i,
    input  logic        interlace_flag_i,
    input  logic        irq_clr_i,
    output logic        sync_active_o,
    output logic [1:0]  state_o,
    output logic [11:0] htotal_o,
    output logic [10:0] vtotal_o,
    output logic        interlace_o,
    output logic        mode_change_o,
    output logic        sync_lost_o,
    output logic        irq_o
);

    localparam logic [1:0] ST_NOSYNC  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    logic        hs_cur, hs_prev, fc_cur, fc_prev, il_cur;
    logic [10:0] vt_cur;
    logic        hs_edge, fc_edge;

    logic [12:0] hcnt, hper;
    logic [10:0] lcnt;

    logic        hs_lost, line_to, fc_evt;
    logic [12:0] smp_hper;
    logic [10:0] smp_vt;
    logic        smp_il;

    logic [1:0]  state, state_n;
    logic [12:0] href, href_n;
    logic [10:0] vref, vref_n;
    logic        iref, iref_n;
    logic [3:0]  lock_cnt, lock_n, miss_cnt, miss_n;
    logic [11:0] htot_n;
    logic [10:0] vtot_n;
    logic        il_n, mc_n, sl_n, reload;

    logic [12:0] hdiff;
    logic [10:0] vdiff;
    logic        match;

    assign hs_edge = hs_prev & ~hs_cur;
    assign fc_edge = fc_cur & ~fc_prev;

    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            hs_cur  <= 1'b0;
            hs_prev <= 1'b0;
            fc_cur  <= 1'b0;
            fc_prev <= 1'b0;
            il_cur  <= 1'b0;
            vt_cur  <= '0;
        end else begin
            hs_cur  <= HSYNC_i;
            hs_prev <= hs_cur;
            fc_cur  <= frame_change_i;
            fc_prev <= fc_cur;
            il_cur  <= interlace_flag_i;
            vt_cur  <= vtotal_i;
        end
    end

    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            hcnt <= '0;
            hper <= '0;
            lcnt <= '0;
        end else begin
            if (hs_edge) begin
                hcnt <= 13'd1;
                hper <= hcnt;
            end else if (hcnt != 13'h1FFF) begin
                hcnt <= hcnt + 13'd1;
            end
            if (fc_edge)
                lcnt <= '0;
            else if (hs_edge && lcnt != 11'h7FF)
                lcnt <= lcnt + 11'd1;
        end
    end

    // The FSM sees a registered copy of its qualifiers; the sample takes hper before a coincident line edge updates it.
    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            hs_lost  <= 1'b0;
            line_to  <= 1'b0;
            fc_evt   <= 1'b0;
            smp_hper <= '0;
            smp_vt   <= '0;
            smp_il   <= 1'b0;
        end else begin
            hs_lost <= (hcnt >= 13'(HS_TIMEOUT));
            line_to <= (lcnt == 11'h7FF);
            fc_evt  <= fc_edge;
            if (fc_edge) begin
                smp_hper <= hper;
                smp_vt   <= vt_cur;
                smp_il   <= il_cur;
            end
        end
    end

    always_comb begin
        hdiff = (smp_hper >= href) ? (smp_hper - href) : (href - smp_hper);
        vdiff = (smp_vt >= vref) ? (smp_vt - vref) : (vref - smp_vt);
        match = (hdiff <= 13'(HTOL)) && (vdiff <= 11'(VTOL)) && (smp_il == iref);
    end

    always_comb begin
        state_n = state;
        href_n  = href;
        vref_n  = vref;
        iref_n  = iref;
        lock_n  = lock_cnt;
        miss_n  = miss_cnt;
        htot_n  = htotal_o;
        vtot_n  = vtotal_o;
        il_n    = interlace_o;
        mc_n    = 1'b0;
        sl_n    = 1'b0;
        reload  = 1'b0;
        case (state)
            ST_NOSYNC: begin
                if (fc_evt && !hs_lost) begin
                    reload  = 1'b1;
                    state_n = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (hs_lost || line_to) begin
                    state_n = ST_NOSYNC;
                end else if (fc_evt && match) begin
                    lock_n = lock_cnt + 4'd1;
                    if (lock_n == 4'(LOCK_FRAMES)) begin
                        state_n = ST_LOCKED;
                        miss_n  = '0;
                        htot_n  = (href > 13'd4095) ? 12'hFFF : href[11:0];
                        vtot_n  = vref;
                        il_n    = iref;
                        mc_n    = 1'b1;
                    end
                end else if (fc_evt) begin
                    reload = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (hs_lost || line_to) begin
                    state_n = ST_NOSYNC;
                    sl_n    = 1'b1;
                end else if (fc_evt && match) begin
                    miss_n = '0;
                end else if (fc_evt) begin
                    miss_n = miss_cnt + 4'd1;
                    if (miss_n == 4'(MISS_LIMIT)) begin
                        reload  = 1'b1;
                        state_n = ST_ACQUIRE;
                        sl_n    = 1'b1;
                    end
                end
            end
            default: state_n = ST_NOSYNC;
        endcase
        if (reload) begin
            href_n = smp_hper;
            vref_n = smp_vt;
            iref_n = smp_il;
            lock_n = 4'd1;
        end
    end

    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_NOSYNC;
            href          <= '0;
            vref          <= '0;
            iref          <= 1'b0;
            lock_cnt      <= '0;
            miss_cnt      <= '0;
            htotal_o      <= '0;
            vtotal_o      <= '0;
            interlace_o   <= 1'b0;
            mode_change_o <= 1'b0;
            sync_lost_o   <= 1'b0;
        end else begin
            state         <= state_n;
            href          <= href_n;
            vref          <= vref_n;
            iref          <= iref_n;
            lock_cnt      <= lock_n;
            miss_cnt      <= miss_n;
            htotal_o      <= htot_n;
            vtotal_o      <= vtot_n;
            interlace_o   <= il_n;
            mode_change_o <= mc_n;
            sync_lost_o   <= sl_n;
        end
    end

    assign state_o       = state;
    assign sync_active_o = (state == ST_LOCKED);

`ifdef SYNC_MON_IRQ_EN
    logic clr_cur;

    // A set event in the same cycle as a clear keeps the interrupt asserted.
    always_ff @(posedge PCLK_i or posedge reset_i) begin
        if (reset_i) begin
            clr_cur <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            clr_cur <= irq_clr_i;
            if (mc_n || sl_n)
                irq_o <= 1'b1;
            else if (clr_cur)
                irq_o <= 1'b0;
        end
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o          = 1'b0;
`endif

endmodule
